// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit: 32 shift-add or restoring shift-subtract steps,
// then a two-cycle fix-up (sign correction, then HI/LO write-back with done).
module pipe_mdu (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic        cancel,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] opd;
    logic [31:0] a_orig;
    logic        is_div;
    logic        div_zero;
    logic        neg_q;
    logic        neg_r;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [63:0] div_next;
    logic [63:0] fix_val;
    logic        fix_done;
    logic        accept;

    assign a_neg = ~mdop[0] & ea[31];
    assign b_neg = ~mdop[0] & eb[31];
    assign a_mag = a_neg ? (32'd0 - ea) : ea;
    assign b_mag = b_neg ? (32'd0 - eb) : eb;

    // Multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Partial remainder in the high half, dividend/quotient bits in the low half.
    assign rem_sh   = {acc[63:32], acc[31]};
    assign diff     = rem_sh - {1'b0, opd};
    assign div_next = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                               : {diff[31:0], acc[30:0], 1'b1};

    always_comb begin
        fix_val = acc;
        if (!is_div) begin
            fix_val = neg_q ? (64'd0 - acc) : acc;
        end else if (div_zero) begin
            fix_val = {a_orig, 32'hFFFF_FFFF};
        end else begin
            fix_val[63:32] = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
            fix_val[31:0]  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        end
    end

    assign fix_done = (state == StFix) && (count == 6'd33);
    assign done     = fix_done & ~cancel;
    assign busy     = (state != StIdle);
    assign stall    = busy | (start & (state == StIdle));
    assign accept   = start & ~cancel & ((state == StIdle) | fix_done);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            count    <= 6'd0;
            acc      <= 64'd0;
            opd      <= 32'd0;
            a_orig   <= 32'd0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (cancel && state != StIdle) begin
            state <= StIdle;
            count <= 6'd0;
        end else begin
            unique case (state)
                StIdle: ;
                StMul, StDiv: begin
                    acc   <= (state == StMul) ? mul_next : div_next;
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= StFix;
                end
                StFix: begin
                    if (count == 6'd32) begin
                        acc   <= fix_val;
                        count <= 6'd33;
                    end else begin
                        hi    <= acc[63:32];
                        lo    <= acc[31:0];
                        state <= StIdle;
                        count <= 6'd0;
                    end
                end
                default: state <= StIdle;
            endcase
            // Loading a new op overrides the FIX exit so back-to-back issue works.
            if (accept) begin
                state    <= mdop[1] ? StDiv : StMul;
                count    <= 6'd0;
                acc      <= {32'd0, mdop[1] ? a_mag : b_mag};
                opd      <= mdop[1] ? b_mag : a_mag;
                a_orig   <= ea;
                is_div   <= mdop[1];
                div_zero <= (eb == 32'd0);
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mdu.sv
// Self-checking bench for pipe_mdu: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_pipe_mdu;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [1:0]  mdop;
    logic [31:0] ea, eb;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    pipe_mdu dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .ea    (ea),
        .eb    (eb),
        .cancel(cancel),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; mdop = op; ea = a; eb = b;
        @(posedge clock);
        #1;
        start = 1'b0; mdop = 2'($urandom); ea = $urandom; eb = $urandom;
    endtask

    // Returns the negedge index (1 = first after the issuing edge) where done was seen.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int j = 1; j <= 40 && lat == 0; j++) begin
            @(negedge clock);
            if (done) lat = j;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat;
        issue(op, a, b);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd34);
        @(posedge clock);
        #1;
        chk({tag, "_hilo"}, {hi, lo}, exp);
        chk({tag, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int base;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp, prev;

        reset = 1'b1; start = 1'b1; cancel = 1'b0; mdop = 2'd0; ea = 32'd0; eb = 32'd0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd1);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; start = 1'b0;

        run_op("mult", 2'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
        run_op("div_zero", 2'd2, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

        // hi=5, lo=6 then cancel a mult mid-flight.
        run_op("setup", 2'd3, 32'd47, 32'd7, {32'd5, 32'd6});
        base = done_cnt;
        issue(2'd0, $urandom, $urandom);
        repeat (9) @(negedge clock);
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hilo", {hi, lo}, {32'd5, 32'd6});
        chk("cancel_nodone", 64'(done_cnt - base), 64'd0);
        run_op("after_cancel", 2'd1, 32'd3, 32'd4, 64'd12);

        // Cancel during the done cycle wins over write-back.
        prev = {hi, lo};
        issue(2'd1, 32'd9, 32'd9);
        wait_done(lat);
        cancel = 1'b1;
        #1;
        chk("fixcancel_done", 64'(done), 64'd0);
        @(posedge clock);
        #1;
        cancel = 1'b0;
        chk("fixcancel_hilo", {hi, lo}, prev);
        chk("fixcancel_busy", 64'(busy), 64'd0);

        // Back-to-back: start held through the done cycle.
        @(negedge clock);
        start = 1'b1; mdop = 2'd1; ea = 32'd1000; eb = 32'd1000;
        @(posedge clock);
        #1;
        ea = 32'hFFFF_FFFB; eb = 32'd3; mdop = 2'd2;
        wait_done(lat);
        chk("b2b_lat1", 64'(lat), 64'd34);
        @(posedge clock);
        #1;
        start = 1'b0; ea = $urandom; eb = $urandom;
        chk("b2b_hilo1", {hi, lo}, 64'd1000000);
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("b2b_lat2", 64'(lat), 64'd34);
        @(posedge clock);
        #1;
        chk("b2b_hilo2", {hi, lo}, model(2'd2, 32'hFFFF_FFFB, 32'd3));

        // Start held while busy must not queue a second op.
        base = done_cnt;
        @(negedge clock);
        start = 1'b1; mdop = 2'd3; ea = 32'd50; eb = 32'd5;
        repeat (10) @(negedge clock);
        start = 1'b0;
        repeat (70) @(posedge clock);
        #1;
        chk("hold_once", 64'(done_cnt - base), 64'd1);
        chk("hold_hilo", {hi, lo}, {32'd0, 32'd10});

        // Reset mid-divide.
        issue(2'd2, 32'd12345, 32'd17);
        repeat (19) @(negedge clock);
        start = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd1);
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        base = done_cnt;
        repeat (40) @(posedge clock);
        #1;
        chk("midrst_nodone", 64'(done_cnt - base), 64'd0);
        run_op("post_rst", 2'd0, 32'hFFFF_FFFD, 32'd7, model(2'd0, 32'hFFFF_FFFD, 32'd7));

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
